min_pulse_gen: RTL

MIN_PULSE_GEN -- requirements
Module: min_pulse_gen

---
 rtl/min_pulse_gen_pkg.sv | 18 +
 rtl/min_pulse_gen.sv | 97 +++++++++
 2 files changed

// File: rtl/min_pulse_gen_pkg.sv
// Shared types for the minimum-width pulse generator: FSM state encoding and
// the counter-width helper used to size the cycle counter.
package min_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // One spare bit above the largest phase length so the counter can never wrap.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int max_c;
    max_c = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return $clog2(max_c) + 1;
  endfunction

endpackage

// File: rtl/min_pulse_gen.sv
// Stretches a start strobe into a HOLD_CYCLES-wide pulse followed by a GAP_CYCLES
// lockout. Define MIN_PULSE_GEN_QUEUE_EN to remember one request made while busy.
module min_pulse_gen
  import min_pulse_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_out,
  output logic o_busy,
  output logic o_done
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             requeue_d;

`ifdef MIN_PULSE_GEN_QUEUE_EN
  logic pend_q;

  // A request on the final GAP edge itself is honoured just like a stored one.
  assign requeue_d = pend_q | i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q <= 1'b0;
    end else if (state_q == GAP && cnt_q == GAP_LAST) begin
      pend_q <= 1'b0;
    end else if (o_busy && i_start) begin
      pend_q <= 1'b1;
    end
  end
`else
  assign requeue_d = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_out   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            o_out   <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= GAP;
            cnt_q   <= '0;
            o_out   <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (requeue_d) begin
              state_q <= HOLD;
              o_out   <= 1'b1;
            end else begin
              state_q <= IDLE;
              o_busy  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          o_out   <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
